// File: rtl/mult_div_seq.sv
// rtl/mult_div_seq.sv - sequential signed Booth multiply / restoring divide unit with HI/LO results
module mult_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   ah_q, ah_d;
  logic [WIDTH-1:0] al_q, al_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   b_ext, booth_sum, mult_ah_n;
  logic [WIDTH-1:0] mult_al_n;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   div_trial, div_diff, div_ah_n;
  logic             div_ge;
  logic [WIDTH-1:0] div_al_n, quo, rem;

  // Booth accumulator is one bit wider so subtracting the most-negative b cannot overflow.
  always_comb begin
    b_ext = {b_q[WIDTH-1], b_q};
    case ({al_q[0], qm1_q})
      2'b01:   booth_sum = ah_q + b_ext;
      2'b10:   booth_sum = ah_q - b_ext;
      default: booth_sum = ah_q;
    endcase
    mult_ah_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mult_al_n = {booth_sum[0], al_q[WIDTH-1:1]};

    a_mag     = a[WIDTH-1] ? -a : a;
    b_mag     = b_q[WIDTH-1] ? -b_q : b_q;
    div_trial = {ah_q[WIDTH-1:0], al_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, b_mag};
    div_ge    = (div_trial >= {1'b0, b_mag});
    div_ah_n  = div_ge ? div_diff : div_trial;
    div_al_n  = {al_q[WIDTH-2:0], div_ge};
    quo       = neg_quo_q ? -div_al_n : div_al_n;
    rem       = neg_rem_q ? -div_ah_n[WIDTH-1:0] : div_ah_n[WIDTH-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ah_d       = ah_q;
    al_d       = al_q;
    qm1_d      = qm1_q;
    b_d        = b_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          b_d        = b;
          neg_quo_d  = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d  = a[WIDTH-1];
          div_zero_d = 1'b0;
          cnt_d      = CW'(WIDTH);
          busy_d     = 1'b1;
          ah_d       = '0;
          qm1_d      = 1'b0;
          al_d       = op ? a_mag : a;
          state_d    = op ? DIV : MULT;
        end
      end
      MULT: begin
        ah_d  = mult_ah_n;
        al_d  = mult_al_n;
        qm1_d = al_q[0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FINISH;
          done_d  = 1'b1;
          hi_d    = mult_ah_n[WIDTH-1:0];
          lo_d    = mult_al_n;
        end
      end
      DIV: begin
        // A zero divisor spends its single DIV cycle here so done lands one cycle after accept.
        if (b_q == '0) begin
          state_d    = FINISH;
          done_d     = 1'b1;
          div_zero_d = 1'b1;
          cnt_d      = '0;
        end else begin
          ah_d  = div_ah_n;
          al_d  = div_al_n;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = FINISH;
            done_d  = 1'b1;
            hi_d    = rem;
            lo_d    = quo;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ah_q       <= '0;
      al_q       <= '0;
      qm1_q      <= 1'b0;
      b_q        <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ah_q       <= ah_d;
      al_q       <= al_d;
      qm1_q      <= qm1_d;
      b_q        <= b_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// tb/tb_mult_div_seq.sv - directed-vector bench for mult_div_seq at WIDTH=32 and WIDTH=8
module tb_mult_div_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start32 = 1'b0, op32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, dz32;
  logic [31:0] hi32, lo32;

  logic        start8 = 1'b0, op8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int n_pass = 0;
  int n_total = 0;

  mult_div_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
  );

  mult_div_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // inj > 0 drives a fresh start with new operands right after cycle inj.
  task automatic run32(input logic o, input logic [31:0] x, input logic [31:0] y, input int inj,
                       output logic busy0, output logic dz0, output int dcyc, output int dcnt,
                       output logic [31:0] rh, output logic [31:0] rl, output logic rdz);
    @(negedge clk);
    start32 = 1'b1; op32 = o; a32 = x; b32 = y;
    @(posedge clk); #1;
    start32 = 1'b0;
    busy0 = busy32; dz0 = dz32;
    dcyc = -1; dcnt = 0; rh = '0; rl = '0; rdz = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done32) begin
        dcnt++;
        if (dcyc < 0) begin dcyc = k; rh = hi32; rl = lo32; rdz = dz32; end
      end
      if (k == inj) begin start32 = 1'b1; op32 = 1'b1; a32 = 32'd1; b32 = 32'd1; end
      if (k == inj + 1) start32 = 1'b0;
    end
  endtask

  task automatic run8(input logic o, input logic [7:0] x, input logic [7:0] y,
                      output int dcyc, output logic [7:0] rh, output logic [7:0] rl);
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0;
    dcyc = -1; rh = '0; rl = '0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done8 && dcyc < 0) begin dcyc = k; rh = hi8; rl = lo8; end
    end
  endtask

  logic        busy0, dz0, rdz;
  int          dcyc, dcnt;
  logic [31:0] rh, rl;
  logic [7:0]  rh8, rl8;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_dz", 64'(dz32), 64'd0);
    check("rst_hi", 64'(hi32), 64'd0);
    check("rst_lo", 64'(lo32), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run32(1'b0, 32'd7, 32'hFFFF_FFFD, 0, busy0, dz0, dcyc, dcnt, rh, rl, rdz);
    check("mul1_busy0", 64'(busy0), 64'd1);
    check("mul1_dcyc", 64'(dcyc), 64'd32);
    check("mul1_dcnt", 64'(dcnt), 64'd1);
    check("mul1_hi", 64'(rh), 64'hFFFF_FFFF);
    check("mul1_lo", 64'(rl), 64'hFFFF_FFEB);
    check("idle_busy", 64'(busy32), 64'd0);

    run32(1'b0, 32'h8000_0000, 32'h8000_0000, 0, busy0, dz0, dcyc, dcnt, rh, rl, rdz);
    check("mul2_hi", 64'(rh), 64'h4000_0000);
    check("mul2_lo", 64'(rl), 64'h0000_0000);

    run32(1'b1, 32'hFFFF_FFF9, 32'd2, 0, busy0, dz0, dcyc, dcnt, rh, rl, rdz);
    check("div1_dcyc", 64'(dcyc), 64'd32);
    check("div1_lo", 64'(rl), 64'hFFFF_FFFD);
    check("div1_hi", 64'(rh), 64'hFFFF_FFFF);

    run32(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, busy0, dz0, dcyc, dcnt, rh, rl, rdz);
    check("div2_lo", 64'(rl), 64'h8000_0000);
    check("div2_hi", 64'(rh), 64'h0);
    check("div2_dz", 64'(rdz), 64'd0);

    run32(1'b0, 32'h0001_2345, 32'h0000_0100, 0, busy0, dz0, dcyc, dcnt, rh, rl, rdz);
    check("pre_lo", 64'(rl), 64'h0123_4500);

    run32(1'b1, 32'd9, 32'd0, 0, busy0, dz0, dcyc, dcnt, rh, rl, rdz);
    check("dz_dcyc", 64'(dcyc), 64'd1);
    check("dz_dcnt", 64'(dcnt), 64'd1);
    check("dz_flag", 64'(rdz), 64'd1);
    check("dz_hi", 64'(rh), 64'h0);
    check("dz_lo", 64'(rl), 64'h0123_4500);
    check("dz_sticky", 64'(dz32), 64'd1);
    check("dz_lo_hold", 64'(lo32), 64'h0123_4500);

    run32(1'b0, 32'd3, 32'd4, 0, busy0, dz0, dcyc, dcnt, rh, rl, rdz);
    check("dz_clear", 64'(dz0), 64'd0);
    check("mul3_lo", 64'(rl), 64'd12);

    run32(1'b0, 32'd100, 32'd200, 10, busy0, dz0, dcyc, dcnt, rh, rl, rdz);
    check("inj_dcyc", 64'(dcyc), 64'd32);
    check("inj_dcnt", 64'(dcnt), 64'd1);
    check("inj_hi", 64'(rh), 64'h0);
    check("inj_lo", 64'(rl), 64'h4E20);

    @(negedge clk);
    start32 = 1'b1; op32 = 1'b1; a32 = 32'd100; b32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_busy", 64'(busy32), 64'd0);
    check("mrst_done", 64'(done32), 64'd0);
    check("mrst_dz", 64'(dz32), 64'd0);
    check("mrst_hi", 64'(hi32), 64'd0);
    check("mrst_lo", 64'(lo32), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run8(1'b0, 8'd5, 8'hFC, dcyc, rh8, rl8);
    check("w8_mul_dcyc", 64'(dcyc), 64'd8);
    check("w8_mul_hi", 64'(rh8), 64'hFF);
    check("w8_mul_lo", 64'(rl8), 64'hEC);

    run8(1'b0, 8'h80, 8'h80, dcyc, rh8, rl8);
    check("w8_mneg_hi", 64'(rh8), 64'h40);
    check("w8_mneg_lo", 64'(rl8), 64'h00);

    run8(1'b1, 8'h80, 8'hFF, dcyc, rh8, rl8);
    check("w8_ovf_lo", 64'(rl8), 64'h80);
    check("w8_ovf_hi", 64'(rh8), 64'h00);

    run8(1'b1, 8'd127, 8'hF6, dcyc, rh8, rl8);
    check("w8_div_dcyc", 64'(dcyc), 64'd8);
    check("w8_div_lo", 64'(rl8), 64'hF4);
    check("w8_div_hi", 64'(rh8), 64'h07);

    run32(1'b0, 32'd7, 32'hFFFF_FFFD, 0, busy0, dz0, dcyc, dcnt, rh, rl, rdz);
    check("post_rst_dcyc", 64'(dcyc), 64'd32);
    check("post_rst_lo", 64'(rl), 64'hFFFF_FFEB);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
